// File: rtl/ibus_responder.sv
// ibus_responder: fixed-latency instruction-bus slave backed by a word-addressed
// instruction store, with a preload port for loading program images.

package ibus_pkg;

    typedef struct packed {
        logic        valid;
        logic [63:0] addr;
    } ibus_req_t;

    typedef struct packed {
        logic        addr_ok;
        logic        data_ok;
        logic [31:0] data;
    } ibus_resp_t;

endpackage

// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | ready; accepts a request when ireq.valid is high (addr_ok)
// WAIT  | request accepted, latency down-counter running
// RESP  | data_ok high for one cycle with the latched word, then IDLE
module ibus_responder
    import ibus_pkg::*;
#(
    parameter logic [63:0] BASE    = 64'h0000_0000_8000_0000,
    parameter int          DEPTH   = 1024,
    parameter int          LATENCY = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  ibus_req_t                ireq,
    output ibus_resp_t               iresp,
    input  logic                     init_we,
    input  logic [$clog2(DEPTH)-1:0] init_idx,
    input  logic [31:0]              init_data
);

    localparam int          AW       = $clog2(DEPTH);
    localparam logic [63:0] SPAN     = 64'(DEPTH) * 64'd4;
    localparam logic [3:0]  CNT_INIT = 4'(LATENCY - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [3:0]  cnt;
    logic [3:0]  cnt_nxt;
    logic [31:0] rdata_q;
    logic [31:0] rdata_nxt;

    logic [31:0] mem [DEPTH];

    logic [63:0] off;
    logic [AW-1:0] idx;
    logic        in_range;
    logic        accept;

    // Address decode; off is a full 64-bit difference so addr<BASE shows up as a
    // huge offset and is rejected both by the explicit compare and the span check.
    always_comb begin
        off      = ireq.addr - BASE;
        idx      = off[AW+1:2];
        in_range = (ireq.addr >= BASE) && (off < SPAN) && (ireq.addr[1:0] == 2'b00);
        accept   = reset && (state == IDLE) && ireq.valid;
    end

    // Preload port; the store is deliberately left out of reset so images survive it.
    always_ff @(posedge clk) begin
        if (init_we) begin
            mem[init_idx] <= init_data;
        end
    end

    // State, latency counter and response word registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            cnt     <= 4'd0;
            rdata_q <= 32'h0000_0000;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            rdata_q <= rdata_nxt;
        end
    end

    // Next-state logic; the store is read at the accepting edge, so a preload
    // write to the same word on that edge is not seen (old word returned).
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        rdata_nxt = rdata_q;
        case (state)
            IDLE: begin
                if (accept) begin
                    rdata_nxt = in_range ? mem[idx] : 32'h0000_0000;
                    cnt_nxt   = CNT_INIT;
                    state_nxt = (CNT_INIT == 4'd0) ? RESP : WAIT;
                end
            end
            WAIT: begin
                cnt_nxt = cnt - 4'd1;
                if (cnt <= 4'd1) begin
                    cnt_nxt   = 4'd0;
                    state_nxt = RESP;
                end
            end
            RESP: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Response outputs; data is forced to zero outside the data_ok cycle.
    always_comb begin
        iresp         = '0;
        iresp.addr_ok = accept;
        iresp.data_ok = (state == RESP);
        iresp.data    = (state == RESP) ? rdata_q : 32'h0000_0000;
    end

endmodule

// File: tb/tb_ibus_responder.sv
// tb_ibus_responder: directed checks of ibus_responder at LATENCY=2 and LATENCY=1.

module tb_ibus_responder;
    import ibus_pkg::*;

    localparam int DEPTH = 16;

    logic       clk;
    logic       reset;
    ibus_req_t  ireq1;
    ibus_req_t  ireq2;
    ibus_resp_t iresp1;
    ibus_resp_t iresp2;
    logic       init_we;
    logic [3:0] init_idx;
    logic [31:0] init_data;

    int n_checks = 0;
    int n_errors = 0;

    ibus_responder #(.BASE(64'h8000_0000), .DEPTH(DEPTH), .LATENCY(2)) u_dut2 (
        .clk       (clk),
        .reset     (reset),
        .ireq      (ireq2),
        .iresp     (iresp2),
        .init_we   (init_we),
        .init_idx  (init_idx),
        .init_data (init_data)
    );

    ibus_responder #(.BASE(64'h8000_0000), .DEPTH(DEPTH), .LATENCY(1)) u_dut1 (
        .clk       (clk),
        .reset     (reset),
        .ireq      (ireq1),
        .iresp     (iresp1),
        .init_we   (init_we),
        .init_idx  (init_idx),
        .init_data (init_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input logic [3:0] i, input logic [31:0] d);
        init_we   = 1'b1;
        init_idx  = i;
        init_data = d;
        step();
        init_we   = 1'b0;
    endtask

    // One isolated LATENCY=2 transaction starting in the current cycle.
    task automatic txn2(input string tag, input logic [63:0] a, input logic [31:0] exp);
        ireq2.valid = 1'b1;
        ireq2.addr  = a;
        #1;
        check({tag, "_aok"}, 64'(iresp2.addr_ok), 64'd1);
        step();
        ireq2.valid = 1'b0;
        #1;
        check({tag, "_dok_c1"}, 64'(iresp2.data_ok), 64'd0);
        step();
        check({tag, "_dok_c2"}, 64'(iresp2.data_ok), 64'd1);
        check({tag, "_data"}, 64'(iresp2.data), 64'(exp));
        step();
        check({tag, "_dok_c3"}, 64'(iresp2.data_ok), 64'd0);
        check({tag, "_data_c3"}, 64'(iresp2.data), 64'd0);
    endtask

    initial begin
        reset     = 1'b0;
        ireq1     = '0;
        ireq2     = '0;
        init_we   = 1'b0;
        init_idx  = 4'd0;
        init_data = 32'h0;

        // reset state, with a pending request that must not be acknowledged
        ireq2.valid = 1'b1;
        ireq2.addr  = 64'h8000_0000;
        #12;
        check("rst_aok", 64'(iresp2.addr_ok), 64'd0);
        check("rst_dok", 64'(iresp2.data_ok), 64'd0);
        check("rst_data", 64'(iresp2.data), 64'd0);
        check("rst_dok1", 64'(iresp1.data_ok), 64'd0);
        ireq2.valid = 1'b0;
        #1;
        reset = 1'b1;
        step();

        preload(4'd0, 32'h0000_0093);
        preload(4'd1, 32'h0010_0113);
        preload(4'd2, 32'h0020_0193);
        preload(4'd3, 32'hAAAA_0003);
        preload(4'd15, 32'hDEAD_000F);

        // LATENCY=2, valid held high, second request follows immediately
        ireq2.valid = 1'b1;
        ireq2.addr  = 64'h8000_0000;
        #1;
        check("s1_c0_aok", 64'(iresp2.addr_ok), 64'd1);
        check("s1_c0_dok", 64'(iresp2.data_ok), 64'd0);
        step();
        check("s1_c1_aok", 64'(iresp2.addr_ok), 64'd0);
        check("s1_c1_dok", 64'(iresp2.data_ok), 64'd0);
        step();
        check("s1_c2_dok", 64'(iresp2.data_ok), 64'd1);
        check("s1_c2_data", 64'(iresp2.data), 64'h0000_0093);
        ireq2.addr = 64'h8000_0004;
        #1;
        check("s1_c2_aok", 64'(iresp2.addr_ok), 64'd0);
        step();
        check("s1_c3_dok", 64'(iresp2.data_ok), 64'd0);
        check("s1_c3_data", 64'(iresp2.data), 64'd0);
        check("s1_c3_aok", 64'(iresp2.addr_ok), 64'd1);
        step();
        check("s1_c4_dok", 64'(iresp2.data_ok), 64'd0);
        step();
        check("s1_c5_dok", 64'(iresp2.data_ok), 64'd1);
        check("s1_c5_data", 64'(iresp2.data), 64'h0010_0113);
        ireq2.valid = 1'b0;
        step();

        // LATENCY=1 back-to-back
        ireq1.valid = 1'b1;
        ireq1.addr  = 64'h8000_0000;
        #1;
        check("b2b_c0_aok", 64'(iresp1.addr_ok), 64'd1);
        step();
        ireq1.addr = 64'h8000_0004;
        #1;
        check("b2b_c1_dok", 64'(iresp1.data_ok), 64'd1);
        check("b2b_c1_data", 64'(iresp1.data), 64'h0000_0093);
        check("b2b_c1_aok", 64'(iresp1.addr_ok), 64'd0);
        step();
        check("b2b_c2_dok", 64'(iresp1.data_ok), 64'd0);
        check("b2b_c2_aok", 64'(iresp1.addr_ok), 64'd1);
        step();
        ireq1.addr = 64'h8000_0008;
        #1;
        check("b2b_c3_dok", 64'(iresp1.data_ok), 64'd1);
        check("b2b_c3_data", 64'(iresp1.data), 64'h0010_0113);
        check("b2b_c3_aok", 64'(iresp1.addr_ok), 64'd0);
        step();
        check("b2b_c4_aok", 64'(iresp1.addr_ok), 64'd1);
        step();
        ireq1.valid = 1'b0;
        #1;
        check("b2b_c5_dok", 64'(iresp1.data_ok), 64'd1);
        check("b2b_c5_data", 64'(iresp1.data), 64'h0020_0193);
        step();
        check("b2b_c6_dok", 64'(iresp1.data_ok), 64'd0);

        // withdrawal: valid dropped and addr changed after acceptance
        ireq2.valid = 1'b1;
        ireq2.addr  = 64'h8000_0004;
        #1;
        check("wd_c0_aok", 64'(iresp2.addr_ok), 64'd1);
        step();
        ireq2.valid = 1'b0;
        ireq2.addr  = 64'h8000_0010;
        #1;
        check("wd_c1_dok", 64'(iresp2.data_ok), 64'd0);
        step();
        check("wd_c2_dok", 64'(iresp2.data_ok), 64'd1);
        check("wd_c2_data", 64'(iresp2.data), 64'h0010_0113);
        step();
        check("wd_c3_dok", 64'(iresp2.data_ok), 64'd0);
        step();
        check("wd_c4_dok", 64'(iresp2.data_ok), 64'd0);
        step();
        check("wd_c5_dok", 64'(iresp2.data_ok), 64'd0);

        // boundaries
        txn2("bnd_top", 64'h8000_0000 + 64'(4 * DEPTH), 32'h0);
        txn2("bnd_below", 64'h7FFF_FFFC, 32'h0);
        txn2("bnd_misal", 64'h8000_0002, 32'h0);
        txn2("bnd_last", 64'h8000_0000 + 64'(4 * (DEPTH - 1)), 32'hDEAD_000F);

        // preload write colliding with acceptance of the same word
        ireq2.valid = 1'b1;
        ireq2.addr  = 64'h8000_000C;
        init_we     = 1'b1;
        init_idx    = 4'd3;
        init_data   = 32'h5555_0003;
        #1;
        check("col_aok", 64'(iresp2.addr_ok), 64'd1);
        step();
        ireq2.valid = 1'b0;
        init_we     = 1'b0;
        step();
        check("col_dok", 64'(iresp2.data_ok), 64'd1);
        check("col_old", 64'(iresp2.data), 64'hAAAA_0003);
        step();
        txn2("col_new", 64'h8000_000C, 32'h5555_0003);

        // async reset in WAIT
        ireq2.valid = 1'b1;
        ireq2.addr  = 64'h8000_0000;
        #1;
        check("ar_w_aok", 64'(iresp2.addr_ok), 64'd1);
        step();
        ireq2.valid = 1'b0;
        #3;
        reset = 1'b0;
        #1;
        check("ar_w_aok0", 64'(iresp2.addr_ok), 64'd0);
        check("ar_w_dok0", 64'(iresp2.data_ok), 64'd0);
        check("ar_w_data0", 64'(iresp2.data), 64'd0);
        step();
        step();
        #2;
        reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            check("ar_w_nodok", 64'(iresp2.data_ok), 64'd0);
        end

        // async reset in RESP drops data immediately
        ireq2.valid = 1'b1;
        ireq2.addr  = 64'h8000_0004;
        step();
        ireq2.valid = 1'b0;
        step();
        check("ar_r_dok1", 64'(iresp2.data_ok), 64'd1);
        check("ar_r_data1", 64'(iresp2.data), 64'h0010_0113);
        #2;
        reset = 1'b0;
        #1;
        check("ar_r_dok0", 64'(iresp2.data_ok), 64'd0);
        check("ar_r_data0", 64'(iresp2.data), 64'd0);
        #2;
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("ar_r_nodok", 64'(iresp2.data_ok), 64'd0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/ibus_responder.md
Name: ibus_responder

Overview:
- Instruction-bus slave: the responder end of the ibus_req_t / ibus_resp_t protocol that the fetch stage drives.
- Backs the bus with a word-addressed instruction store of configurable depth and fixed response latency.
- Used in simulation and bring-up in place of the real memory/cache path.
- Includes a preload write port so benches and the top level can load program images before releasing the core.

Parameters:
- BASE, 64'h80000000, byte address mapped to word 0 (matches core reset PC)
- DEPTH, 1024, number of 32-bit instruction words (power of two, ≥2)
- LATENCY, 2, cycles from request acceptance edge to data_ok cycle (1..15)

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low reset
- ireq  in  ibus_req_t  request from fetch; fields used: valid, addr (u64)
- iresp  out  ibus_resp_t  response; fields driven: addr_ok, data_ok, data (u32); any other fields tied 0
- init_we  in  1  preload write enable
- init_idx  in  $clog2(DEPTH)  preload word index
- init_data  in  32  preload word

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, counter=0, latched index=0, response data register=0, addr_ok=0, data_ok=0, data=0. Memory contents are not cleared.
- States: IDLE, WAIT, RESP.
- addr_ok: combinational, equals (state==IDLE && ireq.valid).
- data_ok: registered, 1 only in RESP.
- data: 0 whenever data_ok=0.
- IDLE, on a clock edge with addr_ok=1:
  - latch off=ireq.addr-BASE.
  - in_range = (ireq.addr ≥ BASE) && (off < DEPTH*4) && (addr[1:0]==0).
  - load response register with mem[off[..:2]] if in_range, else 32'h00000000.
  - cnt=LATENCY-1; next state RESP if cnt==0, else WAIT.
- WAIT: cnt decrements each edge; at the edge where cnt==1 (reaches 0), go RESP.
- RESP: data_ok=1 and data=response register for exactly one cycle; next edge → IDLE. No new request is accepted in RESP.
- Timing: data_ok is asserted LATENCY cycles after the accepting edge. Minimum spacing between acceptances is LATENCY+1 cycles.
- Request withdrawal: once accepted, a transaction always completes. Dropping ireq.valid or changing ireq.addr in WAIT/RESP has no effect; the requester discards stale data. ireq.addr is sampled only at acceptance.
- Out-of-range, misaligned, or addr<BASE requests complete normally with data=0 (no error flag).
- Preload:
  - When init_we=1, mem[init_idx] <= init_data on the clock edge, independent of state.
  - On a same-edge preload write and acceptance of the same index, the response register gets the old word (read-before-write).
- Reset mid-transaction: aborts immediately; no data_ok is produced afterwards for the aborted request.
- Arithmetic:
  - off is computed in 64 bits, with no wrap: addr<BASE is treated as out of range.
  - The index is off[$clog2(DEPTH)+1:2].

Test Plan:
- Reset, then preload idx0=32'h00000093, idx1=32'h00100113. Hold ireq.valid=1 with addr=64'h80000000 (LATENCY=2) → addr_ok=1 in cycle 0, data_ok=1 with data=32'h00000093 in cycle 2, data_ok=0 in cycle 3; a second request to 0x80000004 is accepted in cycle 3 and returns 32'h00100113 in cycle 5.
- LATENCY=1 back-to-back run at 0x80000000, +4, +8 → one data_ok every 2 cycles, in address order; addr_ok never asserted in the RESP cycle.
- Withdrawal: accept 0x80000004, then drop valid and change addr to 0x80000010 in the following cycle → data_ok still fires with mem[1]; no extra transaction occurs.
- Boundary: requests to 0x80000000+4*DEPTH, 0x7FFFFFFC and 0x80000002 → each completes with data_ok=1 and data=0. Request to 0x80000000+4*(DEPTH-1) → returns the last word.
- Async reset: assert reset=0 mid-WAIT, between clock edges → addr_ok/data_ok/data drop to 0 immediately; after release, no data_ok appears without a new request.
- Preload/read collision: init_we on idx 3 in the same cycle as acceptance of 0x8000000C → old word returned; a repeat request returns the new word.
